// File: rtl/unified_mem_resp.sv
`default_nettype none
// ============================================================================
//  Module   : unified_mem_resp
//  Purpose  : Multi-cycle unified-memory responder for the cache controller's
//             re/we/rdy handshake. Captures one line request, counts down a
//             fixed access latency, performs the line-store access and
//             returns a single-cycle ready pulse (plus read data for reads).
//  Revision : 1.0  initial release
// ============================================================================
module unified_mem_resp #(
  parameter int ADDR_W  = 13,
  parameter int LINE_W  = 64,
  parameter int LATENCY = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              re,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [LINE_W-1:0] wdata,
  output logic              rdy,
  output logic [LINE_W-1:0] rdata,
  output logic              busy,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] CNT_LOAD     = 8'(LATENCY - 1);
  // With a one-cycle latency the access happens on the acceptance edge itself.
  localparam bit         SINGLE_CYCLE = (LATENCY == 1);

  state_t            state;
  state_t            state_nx;
  logic [7:0]        cnt;
  logic [7:0]        cnt_nx;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic              op_wr;

  logic              accept;
  logic              mem_wr;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;

  // Backing line store; contents deliberately not reset.
  logic [LINE_W-1:0] mem [0:(1<<ADDR_W)-1];

  // Next-state, countdown and array-access decode for the request FSM.
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    accept    = 1'b0;
    mem_wr    = 1'b0;
    mem_rd    = 1'b0;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    case (state)
      IDLE: begin
        if (re | we) begin
          accept = 1'b1;
          cnt_nx = CNT_LOAD;
          if (SINGLE_CYCLE) begin
            // No captured copy exists yet, so the live request is used.
            state_nx  = DONE;
            mem_addr  = addr;
            mem_wdata = wdata;
            mem_wr    = we;
            mem_rd    = ~we;
          end else begin
            state_nx = BUSY;
          end
        end
      end
      BUSY: begin
        // Initiator withdrawing its request line cancels the access outright,
        // even on the cycle that would otherwise complete it.
        if (op_wr ? ~we : ~re) begin
          state_nx = IDLE;
        end else if (cnt == 8'd1) begin
          state_nx = DONE;
          mem_wr   = op_wr;
          mem_rd   = ~op_wr;
        end else begin
          cnt_nx = cnt - 8'd1;
        end
      end
      DONE: begin
        // Request is still held during the rdy cycle; never re-accept it here.
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // State, request capture, sticky error and read-data register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= 8'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      op_wr   <= 1'b0;
      err     <= 1'b0;
      rdata   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (accept) begin
        addr_q  <= addr;
        wdata_q <= wdata;
        op_wr   <= we;
        if (re & we) begin
          err <= 1'b1;
        end
      end
      if (mem_rd) begin
        rdata <= mem[mem_addr];
      end
    end
  end

  // Line-store write port.
  always_ff @(posedge clk) begin
    if (mem_wr) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  assign rdy  = (state == DONE);
  assign busy = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_unified_mem_resp.sv
`default_nettype none
// ============================================================================
//  Module   : tb_unified_mem_resp
//  Purpose  : Self-checking bench for unified_mem_resp; one instance with
//             LATENCY=4 and one with LATENCY=1, checked against a
//             cycle-numbered transaction model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_unified_mem_resp;

  localparam int AW = 13;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          re    [2];
  logic          we    [2];
  logic [AW-1:0] addr  [2];
  logic [DW-1:0] wdata [2];
  logic          rdy   [2];
  logic          busy  [2];
  logic          err   [2];
  logic [DW-1:0] rdata [2];

  // Reference model state per instance.
  logic [DW-1:0] mm    [2][8192];
  bit            known [2][8192];
  logic [DW-1:0] mrd   [2];
  bit            merr  [2];

  logic [AW-1:0] pool [8];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  unified_mem_resp #(.ADDR_W(AW), .LINE_W(DW), .LATENCY(4)) dut_l4 (
    .clk(clk), .rst_n(rst_n), .re(re[0]), .we(we[0]), .addr(addr[0]),
    .wdata(wdata[0]), .rdy(rdy[0]), .rdata(rdata[0]), .busy(busy[0]), .err(err[0])
  );

  unified_mem_resp #(.ADDR_W(AW), .LINE_W(DW), .LATENCY(1)) dut_l1 (
    .clk(clk), .rst_n(rst_n), .re(re[1]), .we(we[1]), .addr(addr[1]),
    .wdata(wdata[1]), .rdy(rdy[1]), .rdata(rdata[1]), .busy(busy[1]), .err(err[1])
  );

  function automatic int lat(input int d);
    return (d == 0) ? 4 : 1;
  endfunction

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Apply the effect of a completed operation to the model.
  task automatic model_complete(input int d, input bit is_wr, input logic [AW-1:0] a,
                                input logic [DW-1:0] v);
    if (is_wr) begin
      mm[d][a]    = v;
      known[d][a] = 1'b1;
    end else if (known[d][a]) begin
      mrd[d] = mm[d][a];
      check("rdata", rdata[d], mrd[d]);
    end
  endtask

  // One request issued in cycle 0; dropped after rdy, or at abort_at if > 0.
  task automatic xact(input int d, input bit rd, input bit wr, input logic [AW-1:0] a,
                      input logic [DW-1:0] v, input int abort_at);
    int L;
    bit ab;
    L  = lat(d);
    ab = (abort_at > 0);
    re[d] = rd; we[d] = wr; addr[d] = a; wdata[d] = v;
    if (rd && wr) merr[d] = 1'b1;
    for (int c = 0; c <= L + 1; c++) begin
      if (ab && c == abort_at) begin re[d] = 1'b0; we[d] = 1'b0; end
      if (c == 1) begin addr[d] = ~a; wdata[d] = ~v; end
      if (c == L + 1) begin re[d] = 1'b0; we[d] = 1'b0; end
      @(negedge clk);
      check("rdy", rdy[d], (!ab && c == L));
      check("busy", busy[d], ab ? (c >= 1 && c <= abort_at) : (c >= 1 && c <= L));
      if (!ab && c == L) model_complete(d, wr, a, v);
      next_cycle();
    end
    check("err", err[d], merr[d]);
    check("rdata_hold", rdata[d], mrd[d]);
  endtask

  // Two requests back to back; the first is held through its rdy cycle.
  task automatic b2b(input int d, input bit rd1, input logic [AW-1:0] a1, input logic [DW-1:0] v1,
                     input bit rd2, input logic [AW-1:0] a2, input logic [DW-1:0] v2);
    int L;
    L = lat(d);
    re[d] = rd1; we[d] = ~rd1; addr[d] = a1; wdata[d] = v1;
    for (int c = 0; c <= 2 * L + 2; c++) begin
      if (c == L + 1) begin re[d] = rd2; we[d] = ~rd2; addr[d] = a2; wdata[d] = v2; end
      if (c == 2 * L + 2) begin re[d] = 1'b0; we[d] = 1'b0; end
      @(negedge clk);
      check("b2b_rdy", rdy[d], (c == L || c == 2 * L + 1));
      check("b2b_busy", busy[d], ((c >= 1 && c <= L) || (c >= L + 2 && c <= 2 * L + 1)));
      if (c == L)         model_complete(d, ~rd1, a1, v1);
      if (c == 2 * L + 1) model_complete(d, ~rd2, a2, v2);
      next_cycle();
    end
    check("b2b_rdata_hold", rdata[d], mrd[d]);
  endtask

  initial begin
    int d;
    int k;
    int ab;
    logic [AW-1:0] a;
    logic [DW-1:0] v;
    logic [DW-1:0] old;

    pool = '{13'h0A5, 13'h010, 13'h1FF, 13'h000, 13'h1FFF, 13'h123, 13'h0AA, 13'h555};
    for (int i = 0; i < 2; i++) begin
      re[i] = 1'b0; we[i] = 1'b0; addr[i] = '0; wdata[i] = '0;
      mrd[i] = '0; merr[i] = 1'b0;
      for (int j = 0; j < 8192; j++) known[i][j] = 1'b0;
    end

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("reset_rdy", rdy[i], 0);
      check("reset_busy", busy[i], 0);
      check("reset_err", err[i], 0);
      check("reset_rdata", rdata[i], 0);
    end
    next_cycle();
    rst_n = 1'b1;
    next_cycle();

    // Read after write, back to back, LATENCY=4: rdy in cycles 4 and 9.
    b2b(0, 1'b0, 13'h0A5, 64'hDEAD_BEEF_0123_4567, 1'b1, 13'h0A5, '0);

    // Seed every pool address in both instances.
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 8; j++)
        xact(i, 1'b0, 1'b1, pool[j], {$urandom, $urandom}, 0);

    // Held read re-accepted exactly once, in cycle L+1.
    b2b(0, 1'b1, 13'h0A5, '0, 1'b1, 13'h0A5, '0);

    // Abort a write of all-ones in cycle 2; prior contents survive.
    xact(0, 1'b0, 1'b1, 13'h010, '1, 2);
    xact(0, 1'b1, 1'b0, 13'h010, '0, 0);

    // Both lines high: write wins and err is sticky.
    xact(0, 1'b1, 1'b1, 13'h1FF, 64'h5, 0);
    xact(0, 1'b1, 1'b0, 13'h1FF, '0, 0);
    check("rd_1ff", rdata[0], 64'h5);

    // LATENCY=1: single read, then back-to-back reads (rdy in 1 and 3).
    xact(1, 1'b1, 1'b0, 13'h123, '0, 0);
    b2b(1, 1'b1, 13'h0AA, '0, 1'b1, 13'h555, '0);
    b2b(1, 1'b0, 13'h000, 64'h0BAD_F00D_CAFE_1234, 1'b1, 13'h000, '0);

    // Reset in cycle 2 of a write: outputs clear at once, line unchanged.
    old = mm[0][13'h555];
    re[0] = 1'b0; we[0] = 1'b1; addr[0] = 13'h555; wdata[0] = ~old;
    next_cycle();
    next_cycle();
    rst_n = 1'b0;
    #1;
    check("rst_mid_rdy", rdy[0], 0);
    check("rst_mid_busy", busy[0], 0);
    check("rst_mid_err", err[0], 0);
    check("rst_mid_rdata", rdata[0], 0);
    check("rst_mid_err_l1", err[1], 0);
    we[0] = 1'b0;
    for (int i = 0; i < 2; i++) begin mrd[i] = '0; merr[i] = 1'b0; end
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
    xact(0, 1'b1, 1'b0, 13'h555, '0, 0);
    check("rst_line_kept", rdata[0], old);

    // Randomized traffic over the seeded pool.
    for (int n = 0; n < 60; n++) begin
      d = int'($urandom_range(0, 1));
      a = pool[$urandom_range(0, 7)];
      v = {$urandom, $urandom};
      k = int'($urandom_range(0, 7));
      ab = (d == 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      if (k == 7)
        b2b(d, $urandom_range(0, 1) == 1, a, v, 1'b1, pool[$urandom_range(0, 7)], '0);
      else if (k == 0)
        xact(d, 1'b1, 1'b1, a, v, ab);
      else if (k <= 3)
        xact(d, 1'b0, 1'b1, a, v, ab);
      else
        xact(d, 1'b1, 1'b0, a, v, ab);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
